// File: rtl/bus_arbiter_reg.sv
// bus_arbiter_reg: registered bus multiplexer with one-hot gate arbitration,
// a sticky multi-driver fault FSM and a saturating conflict counter.
// Build option: define BUS_ARBITER_PRIORITY_EN to resolve conflicts by
// driving the lowest-index requester. Without it, conflicts hold the bus.
module bus_arbiter_reg #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 4,
  parameter int SIDW  = $clog2(NSRC)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NSRC*WIDTH-1:0] Din,
  input  logic [NSRC-1:0]       Gate,
  input  logic                  ClrErr,
  output logic [WIDTH-1:0]      Bus,
  output logic                  BusValid,
  output logic [SIDW-1:0]       SrcId,
  output logic                  Fault,
  output logic [7:0]            ConflictCnt,
  output logic [1:0]            State
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    FAULT = 2'd2,
    BAD   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             any_req, multi_req, one_hot, load;
  logic [SIDW-1:0]  sel_idx;
  logic [WIDTH-1:0] sel_data;

  // Gate decode: clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    any_req   = |Gate;
    multi_req = |(Gate & (Gate - NSRC'(1)));
    one_hot   = any_req & ~multi_req;
  end

  // Lowest-index requester; for a one-hot gate this is simply the requester.
  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (Gate[i]) begin
        sel_idx  = SIDW'(i);
        sel_data = Din[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef BUS_ARBITER_PRIORITY_EN
  assign load = any_req;
`else
  assign load = one_hot;
`endif

  // Bus register: loads on a winning request, otherwise holds (never released).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Bus      <= '0;
      BusValid <= 1'b0;
      SrcId    <= '0;
    end else begin
      BusValid <= load;
      if (load) begin
        Bus   <= sel_data;
        SrcId <= sel_idx;
      end
    end
  end

  // Conflict counter: ClrErr beats a same-cycle conflict; saturates at 255.
  always_ff @(posedge Clk) begin
    if (Reset || ClrErr)
      ConflictCnt <= 8'd0;
    else if (multi_req && ConflictCnt != 8'hFF)
      ConflictCnt <= ConflictCnt + 8'd1;
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: ClrErr has top priority, then conflict, then gate activity.
  always_comb begin
    state_nxt = state;
    if (ClrErr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (multi_req) state_nxt = FAULT;
                 else if (one_hot) state_nxt = DRIVE;
        DRIVE:   if (multi_req) state_nxt = FAULT;
                 else if (!any_req) state_nxt = IDLE;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign Fault = (state == FAULT);
  assign State = state;

endmodule

// File: tb/tb_bus_arbiter_reg.sv
// Testbench for bus_arbiter_reg (WIDTH=16, NSRC=4): vector table plus a
// counter-saturation sequence, checked through an expected-result queue.
module tb_bus_arbiter_reg;

`ifdef BUS_ARBITER_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, ClrErr;
  logic [63:0] Din;
  logic [3:0]  Gate;
  logic [15:0] Bus;
  logic        BusValid, Fault;
  logic [1:0]  SrcId, State;
  logic [7:0]  ConflictCnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst, clr;
    logic [3:0]  gate;
    logic [63:0] din;
    logic [15:0] bus;
    logic        vld;
    logic [1:0]  sid, st;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[15];
  vec_t sb[$];

  bus_arbiter_reg #(.WIDTH(16), .NSRC(4)) dut (
    .Clk(Clk), .Reset(Reset), .Din(Din), .Gate(Gate), .ClrErr(ClrErr),
    .Bus(Bus), .BusValid(BusValid), .SrcId(SrcId), .Fault(Fault),
    .ConflictCnt(ConflictCnt), .State(State)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(logic rst, logic clr, logic [3:0] gate, logic [63:0] din,
                              logic [15:0] bus, logic vld, logic [1:0] sid,
                              logic [1:0] st, logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.clr = clr; v.gate = gate; v.din = din;
    v.bus = bus; v.vld = vld; v.sid = sid; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, then compare after the edge.
  task automatic apply(vec_t v, string tag);
    vec_t e;
    Reset = v.rst; ClrErr = v.clr; Gate = v.gate; Din = v.din;
    sb.push_back(v);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".Bus"},         32'(Bus),         32'(e.bus));
    chk({tag, ".BusValid"},    32'(BusValid),    32'(e.vld));
    chk({tag, ".SrcId"},       32'(SrcId),       32'(e.sid));
    chk({tag, ".State"},       32'(State),       32'(e.st));
    chk({tag, ".ConflictCnt"}, 32'(ConflictCnt), 32'(e.cnt));
    chk({tag, ".Fault"},       32'(Fault),       32'(e.st == 2'd2));
  endtask

  initial begin
    int exp_cnt;
    //               rst clr gate     din                      bus       vld   sid    st    cnt
    tbl[0]  = mk(1, 0, 4'b0000, 64'h0,                     16'h0000, 0, 2'd0, 2'd0, 8'd0);
    tbl[1]  = mk(0, 0, 4'b0000, 64'h0,                     16'h0000, 0, 2'd0, 2'd0, 8'd0);
    tbl[2]  = mk(0, 0, 4'b0100, 64'h0000_BEEF_0000_0000,   16'hBEEF, 1, 2'd2, 2'd1, 8'd0);
    tbl[3]  = mk(0, 0, 4'b0000, 64'h0000_BEEF_0000_0000,   16'hBEEF, 0, 2'd2, 2'd0, 8'd0);
    tbl[4]  = mk(0, 0, 4'b0000, 64'h1111_2222_3333_4444,   16'hBEEF, 0, 2'd2, 2'd0, 8'd0);
    tbl[5]  = mk(0, 0, 4'b1001, 64'hAAAA_0000_0000_1234,
                 PRIO ? 16'h1234 : 16'hBEEF, PRIO, PRIO ? 2'd0 : 2'd2, 2'd2, 8'd1);
    tbl[6]  = mk(0, 0, 4'b0000, 64'h0,
                 PRIO ? 16'h1234 : 16'hBEEF, 0, PRIO ? 2'd0 : 2'd2, 2'd2, 8'd1);
    tbl[7]  = mk(0, 0, 4'b0010, 64'h0000_0000_0F0F_0000,   16'h0F0F, 1, 2'd1, 2'd2, 8'd1);
    tbl[8]  = mk(0, 1, 4'b0000, 64'h0,                     16'h0F0F, 0, 2'd1, 2'd0, 8'd0);
    tbl[9]  = mk(0, 0, 4'b1000, 64'hAAAA_0000_0000_0000,   16'hAAAA, 1, 2'd3, 2'd1, 8'd0);
    tbl[10] = mk(0, 0, 4'b1000, 64'h1111_0000_0000_0000,   16'h1111, 1, 2'd3, 2'd1, 8'd0);
    tbl[11] = mk(0, 1, 4'b0110, 64'h0000_3333_2222_0000,
                 PRIO ? 16'h2222 : 16'h1111, PRIO, PRIO ? 2'd1 : 2'd3, 2'd0, 8'd0);
    tbl[12] = mk(1, 0, 4'b0001, 64'h0000_0000_0000_5555,   16'h0000, 0, 2'd0, 2'd0, 8'd0);
    tbl[13] = mk(0, 0, 4'b0001, 64'h0000_0000_0000_5555,   16'h5555, 1, 2'd0, 2'd1, 8'd0);
    tbl[14] = mk(0, 0, 4'b0011, 64'h0000_0000_6666_5555,   16'h5555, PRIO, 2'd0, 2'd2, 8'd1);

    Reset = 1'b1; ClrErr = 1'b0; Gate = '0; Din = '0;
    @(negedge Clk);
    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Conflict held well past saturation; counter continues from 1.
    exp_cnt = 1;
    for (int i = 0; i < 300; i++) begin
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      @(negedge Clk);
      apply(mk(0, 0, 4'b0011, 64'h0000_0000_6666_5555, 16'h5555, PRIO, 2'd0, 2'd2,
               8'(exp_cnt)), $sformatf("sat%0d", i));
    end
    @(negedge Clk);
    apply(mk(0, 1, 4'b0000, 64'h0, 16'h5555, 0, 2'd0, 2'd0, 8'd0), "satclr");
    @(negedge Clk);
    apply(mk(0, 0, 4'b0000, 64'h0, 16'h5555, 0, 2'd0, 2'd0, 8'd0), "postclr");

    // Reset mid-operation discards the gate sample, then sampling resumes.
    @(negedge Clk);
    apply(mk(0, 0, 4'b0100, 64'h0000_7777_0000_0000, 16'h7777, 1, 2'd2, 2'd1, 8'd0), "pre_rst");
    @(negedge Clk);
    apply(mk(1, 0, 4'b0001, 64'h0000_0000_0000_5555, 16'h0000, 0, 2'd0, 2'd0, 8'd0), "mid_rst");
    @(negedge Clk);
    apply(mk(0, 0, 4'b0001, 64'h0000_0000_0000_5555, 16'h5555, 1, 2'd0, 2'd1, 8'd0), "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
